// File: rtl/machine_mode_types_1_12_pkg.sv
// Shared types and CSR address constants for the hardware performance
// monitor (mhpmcounter/mhpmevent family, privileged spec 1.12).
package machine_mode_types_1_12_pkg;

  localparam logic [11:0] MHPMCOUNTER_BASE  = 12'hB03;
  localparam logic [11:0] MHPMCOUNTERH_BASE = 12'hB83;
  localparam logic [11:0] MHPMEVENT_BASE    = 12'h323;
  localparam logic [11:0] HPMCOUNTER_BASE   = 12'hC03;
  localparam logic [11:0] HPMCOUNTERH_BASE  = 12'hC83;

  // User-level read-only counter window; any write op here is illegal.
  localparam logic [11:0] UCNT_LO = 12'hC03;
  localparam logic [11:0] UCNT_HI = 12'hC9F;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_M = 2'b11;

  typedef struct packed {
    logic        of;
    logic [22:0] reserved;
    logic [7:0]  sel;
  } mhpmevent_t;

endpackage

// File: rtl/priv_1_12_hpm_counter.sv
// One hardware performance counter plus its mhpmevent register.
// Overflow (sticky OF in mhpmevent[31]) is built only with HPM_OVERFLOW_IRQ_EN.
module priv_1_12_hpm_counter
  import machine_mode_types_1_12_pkg::*;
#(
  parameter int COUNTER_WIDTH = 40,
  parameter int NUM_EVENTS    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_EVENTS-1:0] i_event,
  input  logic                  i_inhibit,
  input  logic                  i_wr_lo,
  input  logic                  i_wr_hi,
  input  logic                  i_wr_evt,
  input  logic [31:0]           i_wdata,
  output logic [63:0]           o_cnt,
  output logic [31:0]           o_evt,
  output logic                  o_of_next
);

  logic [COUNTER_WIDTH-1:0] r_cnt;
  logic [7:0]               r_sel;
  logic                     w_hit;
  logic                     w_inc;
  logic                     w_wrap;
  logic                     w_of;
  mhpmevent_t               w_evt;
  logic                     w_unused;

  // Event select: selector k picks event k-1; 0 or out-of-range counts nothing.
  always_comb begin
    w_hit = 1'b0;
    for (int k = 0; k < NUM_EVENTS; k++)
      if (r_sel == 8'(k + 1)) w_hit = i_event[k];
  end

  // A CSR write to either half suppresses the increment for that cycle.
  assign w_inc  = w_hit & ~i_inhibit & ~i_wr_lo & ~i_wr_hi;
  assign w_wrap = w_inc & (&r_cnt);

  // Counter: write wins over increment; the untouched half keeps its value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_cnt <= '0;
    else if (i_wr_lo) r_cnt[31:0] <= i_wdata;
    else if (i_wr_hi) r_cnt[COUNTER_WIDTH-1:32] <= i_wdata[COUNTER_WIDTH-33:0];
    else if (w_inc)   r_cnt <= r_cnt + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
  end

  // Event selector register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_sel <= '0;
    else if (i_wr_evt) r_sel <= i_wdata[7:0];
  end

`ifdef HPM_OVERFLOW_IRQ_EN
  logic r_of;
  // A wrap in the same cycle as a clearing write keeps OF set.
  assign w_of = w_wrap | (i_wr_evt ? i_wdata[31] : r_of);

  // Sticky overflow flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_of <= 1'b0;
    else          r_of <= w_of;
  end

  assign w_evt.of = r_of;
`else
  assign w_of     = 1'b0;
  assign w_evt.of = 1'b0;
`endif

  assign w_evt.reserved = '0;
  assign w_evt.sel      = r_sel;

  assign o_evt     = w_evt;
  assign o_cnt     = 64'(r_cnt);
  assign o_of_next = w_of;

  assign w_unused = ^{i_wdata, w_wrap};

endmodule

// File: rtl/priv_1_12_hpm.sv
// HPM CSR block: address decode, privilege checks, read mux and write
// operand formation around NUM_COUNTERS priv_1_12_hpm_counter instances.
// Optional overflow interrupt support: HPM_OVERFLOW_IRQ_EN.
module priv_1_12_hpm
  import machine_mode_types_1_12_pkg::*;
#(
  parameter int NUM_COUNTERS  = 4,
  parameter int COUNTER_WIDTH = 40,
  parameter int NUM_EVENTS    = 8
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [11:0]           csr_addr,
  input  logic                  csr_write,
  input  logic                  csr_set,
  input  logic                  csr_clear,
  input  logic                  valid_write,
  input  logic [31:0]           new_csr_val,
  input  logic [1:0]            curr_priv,
  input  logic [31:0]           mcounteren,
  input  logic [31:0]           mcountinhibit,
  input  logic [NUM_EVENTS-1:0] event_pulse,
  output logic [31:0]           old_csr_val,
  output logic                  ack,
  output logic                  invalid_csr,
  output logic                  lcof_irq
);

  logic [NUM_COUNTERS-1:0]        w_hit_mc, w_hit_mch, w_hit_ev, w_hit_hc, w_hit_hch;
  logic [NUM_COUNTERS-1:0][63:0]  w_cnt;
  logic [NUM_COUNTERS-1:0][31:0]  w_evt;
  logic [NUM_COUNTERS-1:0]        w_of_next;
  logic                           w_m_hit, w_u_hit, w_u_denied;
  logic                           w_op, w_ucnt_rng, w_commit;
  logic [31:0]                    w_wdata;
  logic                           w_unused;

  // Per-counter address match for each CSR family.
  always_comb begin
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      w_hit_mc[i]  = (csr_addr == MHPMCOUNTER_BASE  + 12'(i));
      w_hit_mch[i] = (csr_addr == MHPMCOUNTERH_BASE + 12'(i));
      w_hit_ev[i]  = (csr_addr == MHPMEVENT_BASE    + 12'(i));
      w_hit_hc[i]  = (csr_addr == HPMCOUNTER_BASE   + 12'(i));
      w_hit_hch[i] = (csr_addr == HPMCOUNTERH_BASE  + 12'(i));
    end
  end

  // Read mux; hit vectors are one-hot so OR-ing is safe.
  always_comb begin
    old_csr_val = '0;
    w_u_denied  = 1'b0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (w_hit_mc[i] | w_hit_hc[i])   old_csr_val = old_csr_val | w_cnt[i][31:0];
      if (w_hit_mch[i] | w_hit_hch[i]) old_csr_val = old_csr_val | w_cnt[i][63:32];
      if (w_hit_ev[i])                 old_csr_val = old_csr_val | w_evt[i];
      if ((w_hit_hc[i] | w_hit_hch[i]) & ~mcounteren[3+i]) w_u_denied = 1'b1;
    end
  end

  assign w_m_hit    = |{w_hit_mc, w_hit_mch, w_hit_ev};
  assign w_u_hit    = |{w_hit_hc, w_hit_hch};
  assign ack        = w_m_hit | w_u_hit;
  assign w_op       = csr_write | csr_set | csr_clear;
  assign w_ucnt_rng = (csr_addr >= UCNT_LO) && (csr_addr <= UCNT_HI);

  assign invalid_csr = (w_m_hit && curr_priv != PRIV_M)
                     | (w_op && w_ucnt_rng)
                     | (curr_priv == PRIV_U && w_u_denied);

  assign w_wdata  = csr_write ? new_csr_val
                  : csr_set   ? (new_csr_val | old_csr_val)
                  :             (~new_csr_val & old_csr_val);
  assign w_commit = valid_write & w_op & ~invalid_csr;

  for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_cnt
    priv_1_12_hpm_counter #(
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .NUM_EVENTS    (NUM_EVENTS)
    ) u_cnt (
      .i_clk     (CLK),
      .i_rst_n   (nRST),
      .i_event   (event_pulse),
      .i_inhibit (mcountinhibit[3+g]),
      .i_wr_lo   (w_commit & w_hit_mc[g]),
      .i_wr_hi   (w_commit & w_hit_mch[g]),
      .i_wr_evt  (w_commit & w_hit_ev[g]),
      .i_wdata   (w_wdata),
      .o_cnt     (w_cnt[g]),
      .o_evt     (w_evt[g]),
      .o_of_next (w_of_next[g])
    );
  end

`ifdef HPM_OVERFLOW_IRQ_EN
  logic r_lcof;
  // Interrupt tracks the OR of the OF bits, aligned with their update.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_lcof <= 1'b0;
    else       r_lcof <= |w_of_next;
  end
  assign lcof_irq = r_lcof;
`else
  assign lcof_irq = 1'b0;
`endif

  assign w_unused = ^{mcounteren, mcountinhibit, w_of_next};

endmodule

// File: tb/tb_priv_1_12_hpm.sv
module tb_priv_1_12_hpm;
  localparam int NC = 4, CW = 40, NE = 8;
  localparam logic [1:0] M = 2'b11, U = 2'b00;
`ifdef HPM_OVERFLOW_IRQ_EN
  localparam logic OFE = 1'b1;
`else
  localparam logic OFE = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          nRST;
  logic [11:0]   csr_addr;
  logic          csr_write, csr_set, csr_clear, valid_write;
  logic [31:0]   new_csr_val, mcounteren, mcountinhibit;
  logic [1:0]    curr_priv;
  logic [NE-1:0] event_pulse;
  logic [31:0]   old_csr_val;
  logic          ack, invalid_csr, lcof_irq;

  always #5 CLK = ~CLK;

  priv_1_12_hpm #(.NUM_COUNTERS(NC), .COUNTER_WIDTH(CW), .NUM_EVENTS(NE)) dut (
    .CLK(CLK), .nRST(nRST), .csr_addr(csr_addr), .csr_write(csr_write),
    .csr_set(csr_set), .csr_clear(csr_clear), .valid_write(valid_write),
    .new_csr_val(new_csr_val), .curr_priv(curr_priv), .mcounteren(mcounteren),
    .mcountinhibit(mcountinhibit), .event_pulse(event_pulse),
    .old_csr_val(old_csr_val), .ack(ack), .invalid_csr(invalid_csr), .lcof_irq(lcof_irq)
  );

  typedef struct { string name; logic [34:0] exp; } exp_t;
  exp_t sb[$];
  exp_t e;
  logic chk = 1'b0;
  int total = 0, bad = 0;

  // Monitor: pops one expectation per presented access, samples on negedge.
  always @(negedge CLK) begin
    if (chk) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL monitor: access presented with empty scoreboard");
      end else begin
        e = sb.pop_front();
        if ({ack, invalid_csr, lcof_irq, old_csr_val} !== e.exp) begin
          bad++;
          $display("FAIL %s: got ack=%0b inv=%0b lcof=%0b data=%h, want ack=%0b inv=%0b lcof=%0b data=%h",
                   e.name, ack, invalid_csr, lcof_irq, old_csr_val,
                   e.exp[34], e.exp[33], e.exp[32], e.exp[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // op: [0]=write [1]=set [2]=clear
  task automatic wr(input logic [11:0] a, input logic [31:0] v, input logic [2:0] op = 3'b001);
    csr_addr = a; new_csr_val = v; curr_priv = M;
    csr_write = op[0]; csr_set = op[1]; csr_clear = op[2]; valid_write = 1'b1;
    tick();
    csr_write = 0; csr_set = 0; csr_clear = 0; valid_write = 0;
  endtask

  task automatic rd(input string n, input logic [11:0] a, input logic [1:0] p,
                    input logic [31:0] d, input logic ak, input logic iv, input logic lc,
                    input logic w = 1'b0);
    csr_addr = a; curr_priv = p; csr_write = w; valid_write = w; new_csr_val = 32'hDEAD_BEEF;
    sb.push_back('{n, {ak, iv, lc, d}});
    chk = 1'b1;
    tick();
    chk = 1'b0; csr_write = 0; valid_write = 0; curr_priv = M; csr_addr = 12'h000;
  endtask

  task automatic pulse(input logic [NE-1:0] ev, input int n);
    event_pulse = ev;
    repeat (n) tick();
    event_pulse = '0;
  endtask

  initial begin
    nRST = 0; csr_addr = 0; csr_write = 0; csr_set = 0; csr_clear = 0; valid_write = 0;
    new_csr_val = 0; curr_priv = M; mcounteren = 0; mcountinhibit = 0; event_pulse = '0;
    tick(); tick();
    rd("rst_idle", 12'h000, M, 32'h0, 0, 0, 0);
    rd("rst_cnt3", 12'hB03, M, 32'h0, 1, 0, 0);
    nRST = 1;

    wr(12'h323, 32'd2);
    rd("ev3_sel", 12'h323, M, 32'd2, 1, 0, 0);
    pulse(8'h02, 5);
    rd("cnt3_5", 12'hB03, M, 32'd5, 1, 0, 0);
    rd("cnt4_sel0", 12'hB04, M, 32'd0, 1, 0, 0);

    mcountinhibit = 32'h8;
    pulse(8'h02, 10);
    rd("inhibit", 12'hB03, M, 32'd5, 1, 0, 0);
    mcountinhibit = 32'h0;
    pulse(8'h02, 1);
    rd("resume", 12'hB03, M, 32'd6, 1, 0, 0);

    wr(12'h324, 32'd9);
    pulse(8'hFF, 3);
    rd("sel_gt_ne", 12'hB04, M, 32'd0, 1, 0, 0);
    wr(12'h324, 32'h7FFF_FF08);
    rd("ev_rsvd", 12'h324, M, 32'h08, 1, 0, 0);
    pulse(8'h80, 2);
    rd("sel8", 12'hB04, M, 32'd2, 1, 0, 0);
    rd("cnt3_ff", 12'hB03, M, 32'd9, 1, 0, 0);
    wr(12'hB84, 32'hFFFF_FFFF);
    rd("hi_mask", 12'hB84, M, 32'h0000_00FF, 1, 0, 0);

    wr(12'hB83, 32'hFF);
    wr(12'hB03, 32'hFFFF_FFFF);
    rd("pre_wrap_lo", 12'hB03, M, 32'hFFFF_FFFF, 1, 0, 0);
    pulse(8'h02, 1);
    rd("wrap_lo", 12'hB03, M, 32'h0, 1, 0, OFE);
    rd("wrap_hi", 12'hB83, M, 32'h0, 1, 0, OFE);
    rd("of_bit", 12'h323, M, OFE ? 32'h8000_0002 : 32'h2, 1, 0, OFE);
    wr(12'h323, 32'd2);
    rd("of_clr", 12'h323, M, 32'h2, 1, 0, 0);

    pulse(8'h02, 3);
    curr_priv = U;
    rd("u_deny", 12'hC03, U, 32'd3, 1, 1, 0);
    rd("u_deny_c04", 12'hC04, U, 32'd2, 1, 1, 0);
    mcounteren = 32'h8;
    rd("u_ok", 12'hC03, U, 32'd3, 1, 0, 0);
    rd("u_okh", 12'hC83, U, 32'd0, 1, 0, 0);
    rd("m_csrw_c03", 12'hC03, M, 32'd3, 1, 1, 0, 1'b1);
    rd("c03_unchanged", 12'hB03, M, 32'd3, 1, 0, 0);
    rd("u_mlevel", 12'hB03, U, 32'd3, 1, 1, 0);
    rd("unmapped", 12'hB07, M, 32'd0, 0, 0, 0);

    event_pulse = 8'h02;
    wr(12'hB03, 32'h100);
    event_pulse = '0;
    rd("wr_prio", 12'hB03, M, 32'h100, 1, 0, 0);
    wr(12'hB03, 32'h3, 3'b010);
    rd("csr_set", 12'hB03, M, 32'h103, 1, 0, 0);
    wr(12'hB03, 32'h100, 3'b100);
    rd("csr_clear", 12'hB03, M, 32'h003, 1, 0, 0);
    event_pulse = 8'h02;
    wr(12'hB83, 32'h1);
    event_pulse = '0;
    rd("hi_prio_lo", 12'hB03, M, 32'h3, 1, 0, 0);
    rd("hi_prio_hi", 12'hB83, M, 32'h1, 1, 0, 0);

    event_pulse = 8'h02;
    tick(); tick();
    nRST = 0;
    rd("rst_mid_cnt3", 12'hB03, M, 32'h0, 1, 0, 0);
    rd("rst_mid_cnt4h", 12'hB84, M, 32'h0, 1, 0, 0);
    event_pulse = '0;
    nRST = 1;
    rd("rst_ev3", 12'h323, M, 32'h0, 1, 0, 0);
    wr(12'h323, 32'd2);
    pulse(8'h02, 1);
    rd("post_rst", 12'hB03, M, 32'h1, 1, 0, 0);

    repeat (3) tick();
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
